// File: rtl/costas_err_filter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// costas_err_filter : BPSK Costas mixer, I/Q integrate-and-dump, decision-
// directed phase error and PI loop filter feeding the NCO.      Rev 1.0
// -----------------------------------------------------------------------------
module costas_err_filter #(
  parameter int SPS      = 16,
  parameter int ACC_W    = 24,
  parameter int KP_SHIFT = 4,
  parameter int KI_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flagin,
  input  logic signed [15:0]      sample,
  input  logic signed [15:0]      sinvalue,
  input  logic signed [15:0]      cosvalue,
  input  logic                    symbol_sync,
  output logic signed [31:0]      diff,
  output logic                    flagout,
  output logic                    bit_out,
  output logic signed [ACC_W-1:0] err_out
);

  localparam int c_cnt_w = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SPS - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_ERR  = 2'd1,
    ST_FILT = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_cnt_w-1:0]      r_cnt;
  logic signed [ACC_W-1:0] r_acc_i, r_acc_q, r_hold_i, r_hold_q, r_err;
  logic signed [31:0]      r_integ, r_diff;
  logic                    r_flagout, r_bit;

  logic signed [16:0]      w_pi, w_pq;
  logic signed [ACC_W-1:0] w_pi_ext, w_pq_ext, w_sum_i, w_sum_q, w_neg_q, w_err;
  logic signed [33:0]      w_err_ext, w_kp, w_ki, w_integ_sum, w_diff_sum;
  logic signed [31:0]      w_integ_new, w_diff_new;
  logic                    w_dump;

  function automatic logic signed [31:0] sat32(input logic signed [33:0] x);
    if (x[33:31] == 3'b000 || x[33:31] == 3'b111) sat32 = x[31:0];
    else if (x[33])                               sat32 = 32'sh8000_0000;
    else                                          sat32 = 32'sh7FFF_FFFF;
  endfunction

  // Q1.15 x Q1.15 back to Q1.15; 17 bits hold the +1.0 of (-1)*(-1)
  assign w_pi     = 17'((32'(sample) * 32'(cosvalue)) >>> 15);
  assign w_pq     = -17'((32'(sample) * 32'(sinvalue)) >>> 15);
  assign w_pi_ext = {{(ACC_W-17){w_pi[16]}}, w_pi};
  assign w_pq_ext = {{(ACC_W-17){w_pq[16]}}, w_pq};
  assign w_sum_i  = r_acc_i + w_pi_ext;
  assign w_sum_q  = r_acc_q + w_pq_ext;
  assign w_dump   = flagin && !symbol_sync && (r_cnt == c_cnt_last);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_acc_i  <= '0;
      r_acc_q  <= '0;
      r_hold_i <= '0;
      r_hold_q <= '0;
      r_cnt    <= '0;
    end else if (symbol_sync) begin
      r_acc_i <= flagin ? w_pi_ext : '0;
      r_acc_q <= flagin ? w_pq_ext : '0;
      r_cnt   <= flagin ? c_cnt_one : '0;
    end else if (flagin) begin
      if (w_dump) begin
        r_hold_i <= w_sum_i;
        r_hold_q <= w_sum_q;
        r_acc_i  <= '0;
        r_acc_q  <= '0;
        r_cnt    <= '0;
      end else begin
        r_acc_i <= w_sum_i;
        r_acc_q <= w_sum_q;
        r_cnt   <= r_cnt + c_cnt_one;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC:  if (w_dump) w_state_nxt = ST_ERR;
      ST_ERR:  w_state_nxt = ST_FILT;
      ST_FILT: w_state_nxt = w_dump ? ST_ERR : ST_ACC;
      default: w_state_nxt = ST_ACC;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) r_state <= ST_ACC;
    else       r_state <= w_state_nxt;
  end

  // Decision-directed error: rotate Q by the sign of the I decision
  assign w_neg_q = (r_hold_q == c_acc_min) ? c_acc_max : -r_hold_q;
  assign w_err   = r_hold_i[ACC_W-1] ? w_neg_q : r_hold_q;

  assign w_err_ext   = {{(34-ACC_W){r_err[ACC_W-1]}}, r_err};
  assign w_kp        = w_err_ext <<< KP_SHIFT;
  assign w_ki        = w_err_ext <<< KI_SHIFT;
  assign w_integ_sum = {{2{r_integ[31]}}, r_integ} + w_ki;
  assign w_integ_new = sat32(w_integ_sum);
  assign w_diff_sum  = w_kp + {{2{w_integ_new[31]}}, w_integ_new};
  assign w_diff_new  = sat32(w_diff_sum);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_err     <= '0;
      r_bit     <= 1'b0;
      r_integ   <= '0;
      r_diff    <= '0;
      r_flagout <= 1'b0;
    end else begin
      r_flagout <= 1'b0;
      case (r_state)
        ST_ERR: begin
          r_err <= w_err;
          r_bit <= ~r_hold_i[ACC_W-1];
        end
        ST_FILT: begin
          r_integ   <= w_integ_new;
          r_diff    <= w_diff_new;
          r_flagout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign diff    = r_diff;
  assign flagout = r_flagout;
  assign bit_out = r_bit;
  assign err_out = r_err;

endmodule
`default_nettype wire
